// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage plus ID/EX pipeline register of a MIPS-like pipeline.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ifid_valid, ifid_instr    instruction currently held in the IF/ID register
//   rs_addr, rt_addr          register-file read addresses (combinational)
//   rf_data1, rf_data2        register-file read data for rs_addr / rt_addr
//   wb_write/wb_addr/wb_data  write-back port, used for same-cycle bypass
//   flush                     taken branch/jump in EX: kill the decode slot
//   ex_hold                   EX busy: ID/EX contents must not advance
//   stall                     hold PC and IF/ID this cycle (combinational)
//   ex_*                      registered EX-stage controls, fields and operands
//   stall_count               saturating count of cycles with stall=1
//
// Flow control: the decode slot advances into ID/EX on a posedge only when
// stall=0 and flush=0. stall=1 means the upstream stage must present the same
// instruction again next cycle. flush wins over everything except reset and
// forces stall low, because the decode slot is being discarded anyway.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifid_valid,
    input  logic [31:0]      ifid_instr,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    input  logic [31:0]      rf_data1,
    input  logic [31:0]      rf_data2,
    input  logic             wb_write,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_mem_read,
    output logic             ex_reg_write,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_a,
    output logic [31:0]      ex_b,
    output logic [31:0]      ex_imm,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [5:0]  dec_opcode;
    logic [5:0]  dec_funct;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_mem_read;
    logic        dec_reg_write;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic        hazard;

    assign dec_opcode = ifid_instr[31:26];
    assign dec_funct  = ifid_instr[5:0];
    assign rs_addr    = ifid_instr[25:21];
    assign rt_addr    = ifid_instr[20:16];
    assign dec_imm    = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    assign dec_rd     = (dec_opcode == OP_RTYPE) ? ifid_instr[15:11] : ifid_instr[20:16];

    always_comb begin
        dec_mem_read  = 1'b0;
        dec_reg_write = 1'b0;
        case (dec_opcode)
            OP_LW: begin
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_RTYPE, OP_ADDI: dec_reg_write = 1'b1;
            default: ;
        endcase
    end

    // The register file is read and written in the same cycle; the bypass
    // returns the value being written so decode never sees a stale operand.
    // Register 0 is hard-wired to zero and is never bypassed.
    always_comb begin
        dec_a = rf_data1;
        if (rs_addr == 5'd0)
            dec_a = 32'd0;
        else if (wb_write && (wb_addr == rs_addr))
            dec_a = wb_data;
    end

    always_comb begin
        dec_b = rf_data2;
        if (rt_addr == 5'd0)
            dec_b = 32'd0;
        else if (wb_write && (wb_addr == rt_addr))
            dec_b = wb_data;
    end

    // Load-use: a load in EX produces its result too late for the dependent
    // instruction in decode, so one bubble is inserted.
    assign hazard = ex_valid && ex_mem_read && (ex_rt != 5'd0) && ifid_valid &&
                    ((ex_rt == rs_addr) || (ex_rt == rt_addr));

    assign stall = !flush && (ex_hold || hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_opcode    <= '0;
            ex_funct     <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (ex_hold) begin
            // Everything held, operands included: no bypass refresh.
        end else if (hazard) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_reg_write <= 1'b0;
        end else begin
            ex_valid     <= ifid_valid;
            ex_mem_read  <= ifid_valid && dec_mem_read;
            ex_reg_write <= ifid_valid && dec_reg_write;
            ex_opcode    <= dec_opcode;
            ex_funct     <= dec_funct;
            ex_rs        <= rs_addr;
            ex_rt        <= rt_addr;
            ex_rd        <= dec_rd;
            ex_a         <= dec_a;
            ex_b         <= dec_b;
            ex_imm       <= dec_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// behavioural model of the ID/EX register. A second instance with a 4-bit
// stall counter shares all inputs to exercise counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, ifid_valid, wb_write, flush, ex_hold;
    logic [31:0] ifid_instr, rf_data1, rf_data2, wb_data;
    logic [4:0]  wb_addr;

    logic        stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [4:0]  rs_addr, rt_addr, ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_opcode, ex_funct;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] stall_count;

    logic        s4_stall, s4_valid, s4_mr, s4_rw;
    logic [4:0]  s4_rsa, s4_rta, s4_rs, s4_rt, s4_rd;
    logic [5:0]  s4_op, s4_fn;
    logic [31:0] s4_a, s4_b, s4_imm;
    logic [3:0]  s4_count;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall(stall),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .rs_addr(s4_rsa), .rt_addr(s4_rta), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_hold(ex_hold), .stall(s4_stall),
        .ex_valid(s4_valid), .ex_mem_read(s4_mr), .ex_reg_write(s4_rw),
        .ex_opcode(s4_op), .ex_funct(s4_fn), .ex_rs(s4_rs), .ex_rt(s4_rt),
        .ex_rd(s4_rd), .ex_a(s4_a), .ex_b(s4_b), .ex_imm(s4_imm),
        .stall_count(s4_count)
    );

    // Reference model: the instruction sitting in EX, as the ISA describes it.
    typedef struct {
        logic        valid;
        logic        mem_read;
        logic        reg_write;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
    } ex_slot_t;

    ex_slot_t m;
    int       m_cnt16, m_cnt4;
    int       n_pass = 0, n_total = 0;
    logic     obs_stall, exp_stall_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Architectural value of register r as seen by an instruction reading it
    // in a cycle where the write-back port may also be writing it.
    function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (wb_write && wb_addr == r) return wb_data;
        return rf;
    endfunction

    function automatic ex_slot_t decode(input logic [31:0] ins, input logic v);
        ex_slot_t d;
        int op;
        op = int'(ins[31:26]);
        d.valid     = v;
        d.mem_read  = v && (op == 35);
        d.reg_write = v && (op == 35 || op == 0 || op == 8);
        d.opcode    = ins[31:26];
        d.funct     = ins[5:0];
        d.rs        = ins[25:21];
        d.rt        = ins[20:16];
        d.rd        = (op == 0) ? ins[15:11] : ins[20:16];
        d.imm       = 32'(signed'(ins[15:0]));
        d.a         = reg_value(ins[25:21], rf_data1);
        d.b         = reg_value(ins[20:16], rf_data2);
        return d;
    endfunction

    // One clock: check combinational outputs, advance the model, then check
    // the registered outputs just after the edge.
    task automatic do_cycle();
        logic load_use;
        #2;
        load_use = m.valid && m.mem_read && m.rt != 0 && ifid_valid &&
                   (m.rt == ifid_instr[25:21] || m.rt == ifid_instr[20:16]);
        exp_stall_q = !flush && (ex_hold || load_use);
        obs_stall = stall;
        chk("rs_addr", rs_addr, ifid_instr[25:21]);
        chk("rt_addr", rt_addr, ifid_instr[20:16]);
        chk("stall", stall, exp_stall_q);
        if (rst) begin
            m = '{default: '0};
            m_cnt16 = 0;
            m_cnt4 = 0;
        end else begin
            if (exp_stall_q) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush || (!ex_hold && load_use)) begin
                m.valid = 1'b0;
                m.mem_read = 1'b0;
                m.reg_write = 1'b0;
            end else if (!ex_hold) begin
                m = decode(ifid_instr, ifid_valid);
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, m.valid);
        chk("ex_mem_read", ex_mem_read, m.mem_read);
        chk("ex_reg_write", ex_reg_write, m.reg_write);
        chk("stall_count", stall_count, m_cnt16);
        chk("stall_count4", s4_count, m_cnt4);
        if (m.valid) begin
            chk("ex_opcode", ex_opcode, m.opcode);
            chk("ex_funct", ex_funct, m.funct);
            chk("ex_rs", ex_rs, m.rs);
            chk("ex_rt", ex_rt, m.rt);
            chk("ex_rd", ex_rd, m.rd);
            chk("ex_a", ex_a, m.a);
            chk("ex_b", ex_b, m.b);
            chk("ex_imm", ex_imm, m.imm);
        end
        if (rst) begin
            chk("rst_opcode", ex_opcode, 0);
            chk("rst_a", ex_a, 0);
            chk("rst_imm", ex_imm, 0);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; ex_hold = 1'b0; wb_write = 1'b0;
        wb_addr = 5'd0; wb_data = 32'd0; ifid_valid = 1'b0; ifid_instr = 32'd0;
        rf_data1 = 32'd0; rf_data2 = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 3))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b001000;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    logic [31:0] saved_a, saved_b;
    logic [4:0]  saved_rd;

    initial begin
        idle_inputs();
        rst = 1'b1;
        m = '{default: '0};
        m_cnt16 = 0;
        m_cnt4 = 0;
        do_cycle();
        do_cycle();
        chk("reset_valid", ex_valid, 0);
        chk("reset_count", stall_count, 0);
        rst = 1'b0;

        // add $3,$1,$2 with operands 5 and 7
        ifid_valid = 1'b1; ifid_instr = 32'h0022_1820; rf_data1 = 32'd5; rf_data2 = 32'd7;
        do_cycle();
        chk("add_valid", ex_valid, 1);
        chk("add_rd", ex_rd, 3);
        chk("add_a", ex_a, 5);
        chk("add_b", ex_b, 7);
        chk("add_rw", ex_reg_write, 1);

        // lw $4,0($1) followed by dependent add $5,$4,$4
        do_reset();
        ifid_valid = 1'b1; ifid_instr = 32'h8C24_0000; rf_data1 = 32'h100;
        do_cycle();
        chk("lw_mem_read", ex_mem_read, 1);
        ifid_instr = 32'h0084_2820; rf_data1 = 32'h11; rf_data2 = 32'h11;
        do_cycle();
        chk("loaduse_stall", obs_stall, 1);
        chk("loaduse_bubble", ex_valid, 0);
        do_cycle();
        chk("loaduse_nostall", obs_stall, 0);
        chk("loaduse_issue", ex_valid, 1);
        chk("loaduse_rd", ex_rd, 5);
        chk("loaduse_count", stall_count, 1);

        // same-cycle write-back bypass and register 0
        do_reset();
        ifid_valid = 1'b1; ifid_instr = 32'h0002_3020;
        rf_data1 = 32'h55; rf_data2 = 32'h0;
        wb_write = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF;
        do_cycle();
        chk("bypass_b", ex_b, 32'hDEAD_BEEF);
        chk("zero_a", ex_a, 0);
        wb_write = 1'b0;

        // flush with a load-use hazard present
        do_reset();
        ifid_valid = 1'b1; ifid_instr = 32'h8C24_0000;
        do_cycle();
        ifid_instr = 32'h0084_2820; flush = 1'b1;
        do_cycle();
        chk("flush_stall", obs_stall, 0);
        chk("flush_valid", ex_valid, 0);
        chk("flush_count", stall_count, 0);
        flush = 1'b0;

        // EX hold: contents frozen while operands change underneath
        do_reset();
        ifid_valid = 1'b1; ifid_instr = 32'h0022_1820; rf_data1 = 32'd9; rf_data2 = 32'd4;
        do_cycle();
        saved_a = ex_a; saved_b = ex_b; saved_rd = ex_rd;
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rf_data1 = $urandom; rf_data2 = $urandom; ifid_instr = rand_instr();
            do_cycle();
            chk("hold_stall", obs_stall, 1);
        end
        chk("hold_a", ex_a, saved_a);
        chk("hold_b", ex_b, saved_b);
        chk("hold_rd", ex_rd, saved_rd);
        chk("hold_count3", stall_count, 3);
        for (int i = 0; i < 17; i++) do_cycle();
        chk("hold_count20", stall_count, 20);
        chk("hold_sat4", s4_count, 15);

        // reset while a valid instruction is held
        chk("pre_rst_valid", ex_valid, 1);
        rst = 1'b1;
        do_cycle();
        chk("rst_hold_valid", ex_valid, 0);
        chk("rst_hold_count", stall_count, 0);
        chk("rst_hold_rd", ex_rd, 0);
        rst = 1'b0; ex_hold = 1'b0; ifid_valid = 1'b0;
        do_cycle();
        chk("post_rst_valid", ex_valid, 0);

        // randomized traffic; a stalled decode slot is re-presented unchanged
        for (int i = 0; i < 400; i++) begin
            if (!(exp_stall_q && !rst)) begin
                ifid_valid = ($urandom_range(0, 99) < 85);
                ifid_instr = rand_instr();
            end
            rst      = ($urandom_range(0, 99) < 2);
            flush    = ($urandom_range(0, 99) < 8);
            ex_hold  = ($urandom_range(0, 99) < 15);
            wb_write = $urandom_range(0, 1);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            rf_data1 = $urandom;
            rf_data2 = $urandom;
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: CNT_W, 16, width of the saturating stall counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ifid_valid  input  1  decode slot holds a real instruction.
REQ-005 ifid_instr  input  32  instruction in decode.
REQ-006 rs_addr, rt_addr  output  5 each  = ifid_instr[25:21], [20:16]; combinational; drive register-file read addresses 1 and 2.
REQ-007 rf_data1, rf_data2  input  32 each  register-file read data for rs_addr, rt_addr.
REQ-008 wb_write, wb_addr, wb_data  input  1/5/32  the same write-back triple that drives the register-file write port.
REQ-009 flush  input  1  branch/jump resolved taken in EX; kill decode slot.
REQ-010 ex_hold  input  1  EX stage busy; ID/EX contents must not advance.
REQ-011 stall  output  1  hold PC and IF/ID this cycle; combinational.
REQ-012 ex_valid, ex_mem_read, ex_reg_write  output  1 each  registered EX controls.
REQ-013 ex_opcode, ex_funct  output  6 each  registered ifid_instr[31:26], [5:0].
REQ-014 ex_rs, ex_rt, ex_rd  output  5 each  registered source and destination numbers.
REQ-015 ex_a, ex_b, ex_imm  output  32 each  registered operands and sign-extended immediate.
REQ-016 stall_count  output  CNT_W  number of cycles stall was 1.

Function
REQ-017 Decode: lw=100011 sets mem_read=1, reg_write=1; opcode 000000 and addi 001000 set reg_write=1; every other opcode sets both 0.
REQ-018 Destination: opcode 000000 -> instr[15:11]; else instr[20:16]; imm = {16 copies of instr[15], instr[15:0]}.
REQ-019 Operand A: 0 if rs_addr==0; else wb_data if wb_write && wb_addr==rs_addr; else rf_data1 (bypass covers write and read of the same register in one cycle).
REQ-020 Operand B: same rule using rt_addr and rf_data2.
REQ-021 hazard = ex_valid && ex_mem_read && ex_rt!=0 && ifid_valid && (ex_rt==rs_addr || ex_rt==rt_addr).
REQ-022 stall = !flush && (ex_hold || hazard).
REQ-023 Update priority each posedge: rst > flush > ex_hold > hazard > normal.
REQ-024 flush: ex_valid<=0, ex_mem_read<=0, ex_reg_write<=0; data fields don't-care; stall_count unchanged.
REQ-025 ex_hold (no flush): all ex_* registers hold; ex_a/ex_b are not refreshed by bypass while held.
REQ-026 hazard (no flush, no ex_hold): bubble: ex_valid, ex_mem_read, ex_reg_write <= 0; decode instruction stays in IF/ID and issues next cycle with one stall cycle total.
REQ-027 Normal: all ex_* <= decoded values; ex_valid<=ifid_valid; controls forced 0 when ifid_valid=0.
REQ-028 Latency: decode to EX outputs exactly one cycle when stall=0.
REQ-029 stall_count increments by 1 on every posedge where stall=1; saturates at all-ones, no wrap.

Reset
REQ-030 On posedge clk with rst=1 every ex_* output and stall_count become 0; rst overrides flush, ex_hold and hazard.
REQ-031 Reset mid-operation discards the in-flight ID/EX instruction; ex_valid is 0 the cycle after rst drops until a valid instruction issues.
REQ-032 stall is combinational and may be 1 during reset if ex_hold=1; no state changes from it during reset.

Verification
REQ-033 add $3,$1,$2 (0x00221820), rf_data1=5, rf_data2=7 -> next cycle ex_valid=1, ex_rd=3, ex_a=5, ex_b=7, ex_reg_write=1.
REQ-034 lw $4,0($1) issued, then add $5,$4,$4 in decode -> stall=1 one cycle, bubble ex_valid=0, add issues next cycle, stall_count=1.
REQ-035 wb_write=1, wb_addr=2, wb_data=0xDEADBEEF, decode reads rt=2 with rf_data2=0 -> ex_b=0xDEADBEEF; rs=0 with rf_data1=0x55 -> ex_a=0.
REQ-036 flush=1 with hazard present -> stall=0, ex_valid=0, stall_count unchanged.
REQ-037 ex_hold=1 for 3 cycles -> ex_* stable, stall=1, stall_count+=3; CNT_W=4 held 20 cycles -> stall_count=15.
REQ-038 rst=1 while ex_valid=1 and ex_hold=1 -> next cycle all ex_* and stall_count 0.
